// File: rtl/alu_acc_ctrl_if.sv
// Bus bundle between the ALU accumulator controller, its operand/command source and the ALU.
// slave: controller side; master: switch/command source plus ALU side.
interface alu_acc_ctrl_if;
  logic [7:0] DIN;
  logic       LOAD_A;
  logic       LOAD_B;
  logic       EXEC;
  logic [2:0] OPS_IN;
  logic       CI_IN;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic [2:0] ALU_OPS;
  logic       ALU_CI;
  logic [7:0] ALU_OUT;
  logic       ALU_CO;
  logic       ALU_ALO;
  logic       ALU_EQO;
  logic       ALU_Z;
  logic [7:0] ACC;
  logic [3:0] FLAGS;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [7:0] OPCOUNT;

  modport slave (
    input  DIN, LOAD_A, LOAD_B, EXEC, OPS_IN, CI_IN,
    input  ALU_OUT, ALU_CO, ALU_ALO, ALU_EQO, ALU_Z,
    output ALU_A, ALU_B, ALU_OPS, ALU_CI,
    output ACC, FLAGS, BUSY, DONE, ERR, OPCOUNT
  );

  modport master (
    output DIN, LOAD_A, LOAD_B, EXEC, OPS_IN, CI_IN,
    output ALU_OUT, ALU_CO, ALU_ALO, ALU_EQO, ALU_Z,
    input  ALU_A, ALU_B, ALU_OPS, ALU_CI,
    input  ACC, FLAGS, BUSY, DONE, ERR, OPCOUNT
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Sequences operand loads, ALU settle time and result capture for an external combinational ALU.
// Define ALU_CHAIN_EN to feed each result and carry back into operand A / carry-in.
//
// state   | meaning
// IDLE    | accepting LOAD_A/LOAD_B/EXEC, ALU inputs free to change
// SETTLE  | ALU inputs frozen for SETTLE_CYCLES cycles
// CAPTURE | ALU result registered into ACC/FLAGS on the closing edge
module alu_acc_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic           CLK,
  input logic           RST,
  alu_acc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t     state_q, state_d;
  logic [3:0] settle_cnt_q;
  logic [7:0] a_q, b_q, acc_q, opcount_q;
  logic [2:0] ops_q;
  logic [3:0] flags_q;
  logic       carry_q, busy_q, done_q, err_q;

  logic idle, exec_ok, exec_bad, settle_last, capture;

  always_comb begin
    state_d     = state_q;
    idle        = (state_q == IDLE);
    exec_ok     = idle && bus.EXEC && (bus.OPS_IN != 3'd7);
    exec_bad    = idle && bus.EXEC && (bus.OPS_IN == 3'd7);
    settle_last = (settle_cnt_q == 4'(SETTLE_CYCLES - 1));
    capture     = (state_q == CAPTURE);
    case (state_q)
      IDLE:    if (exec_ok) state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      opcount_q    <= '0;
      ops_q        <= '0;
      flags_q      <= '0;
      carry_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= capture;
      err_q   <= exec_bad;

      if (exec_ok) begin
        ops_q        <= bus.OPS_IN;
        settle_cnt_q <= '0;
        busy_q       <= 1'b1;
      end else if (state_q == SETTLE) begin
        settle_cnt_q <= settle_cnt_q + 4'd1;
      end

      // Loads land on the EXEC edge too, so the ALU settles on the new operands.
      if (idle && bus.LOAD_A) a_q <= bus.DIN;
      if (idle && bus.LOAD_B) b_q <= bus.DIN;

      if (capture) begin
        acc_q     <= bus.ALU_OUT;
        flags_q   <= {bus.ALU_CO, bus.ALU_ALO, bus.ALU_EQO, bus.ALU_Z};
        opcount_q <= opcount_q + 8'd1;
        busy_q    <= 1'b0;
      end

`ifdef ALU_CHAIN_EN
      if (capture) begin
        a_q     <= bus.ALU_OUT;
        carry_q <= bus.ALU_CO;
      end else if (idle && bus.LOAD_A) begin
        carry_q <= 1'b0;
      end
`else
      if (exec_ok) carry_q <= bus.CI_IN;
`endif
    end
  end

  assign bus.ALU_A   = a_q;
  assign bus.ALU_B   = b_q;
  assign bus.ALU_OPS = ops_q;
  assign bus.ALU_CI  = carry_q;
  assign bus.ACC     = acc_q;
  assign bus.FLAGS   = flags_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.OPCOUNT = opcount_q;

endmodule

// File: doc/alu_acc_ctrl.md
ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles the ALU inputs are held stable before capture (legal range 1..15).
REQ-002 SHALL have port CLK, input, 1, the single system clock; every register updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port DIN, input, 8, operand data from the switches.
REQ-005 SHALL have ports LOAD_A, LOAD_B and EXEC, input, 1 each, single-cycle click pulses.
REQ-006 SHALL have port OPS_IN, input, 3, the requested ALU op (0 ADD … 6 XOR).
REQ-007 SHALL have port CI_IN, input, 1, external carry-in.
REQ-008 SHALL have ports ALU_A, ALU_B, output, 8 each; ALU_OPS, output, 3; ALU_CI, output, 1: the registered operands, op and carry driving the ALU.
REQ-009 SHALL have ports ALU_OUT, input, 8; ALU_CO, ALU_ALO, ALU_EQO, ALU_Z, input, 1 each: the combinational results returned by the ALU.
REQ-010 SHALL have ports ACC, output, 8, the captured result; FLAGS, output, 4, ordered {CO, ALO, EQO, Z}.
REQ-011 SHALL have ports BUSY, output, 1; DONE, output, 1; ERR, output, 1; OPCOUNT, output, 8.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, SETTLE and CAPTURE.
REQ-013 In IDLE, LOAD_A SHALL set register A to DIN and LOAD_B SHALL set register B to DIN; both SHALL take effect on the same edge when asserted together.
REQ-014 In IDLE, EXEC with OPS_IN<=6 SHALL latch OPS_IN into ALU_OPS, clear the settle counter, set BUSY and enter SETTLE on the next edge.
REQ-015 When EXEC and LOAD_A/LOAD_B arrive in the same IDLE cycle, both SHALL be accepted, and the ALU SHALL see the newly loaded operand(s).
REQ-016 In IDLE, EXEC with OPS_IN=7 SHALL be rejected: no state change, and a one-cycle ERR pulse on the next cycle.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with ALU_A, ALU_B, ALU_OPS and ALU_CI held constant, then enter CAPTURE.
REQ-018 On the CAPTURE edge, ACC SHALL take ALU_OUT and FLAGS SHALL take {ALU_CO, ALU_ALO, ALU_EQO, ALU_Z}; OPCOUNT SHALL increment, wrapping 255->0.
REQ-019 DONE SHALL be high for exactly the one cycle after the capture edge, and the FSM SHALL then be in IDLE with BUSY low.
REQ-020 EXEC to DONE latency SHALL be SETTLE_CYCLES+2 cycles.
REQ-021 LOAD_A, LOAD_B and EXEC arriving while BUSY is high SHALL be ignored and SHALL NOT be queued.
REQ-022 ALU_A and ALU_B SHALL be driven directly from registers A and B, with no combinational path from DIN.

Reset
REQ-023 With RST high at an edge, the block SHALL set: state IDLE; A, B, ACC, ALU_OPS and OPCOUNT 0; FLAGS 0; BUSY, DONE and ERR 0; carry register 0.
REQ-024 RST SHALL win over every simultaneous input, including mid-SETTLE and mid-CAPTURE, so no capture occurs and OPCOUNT is not incremented.

Configuration
REQ-025 Macro ALU_CHAIN_EN SHALL select chaining.
REQ-026 With ALU_CHAIN_EN defined: at CAPTURE, A SHALL also take ALU_OUT and the carry register SHALL take ALU_CO; ALU_CI SHALL be the carry register; LOAD_A SHALL clear the carry register.
REQ-027 Without ALU_CHAIN_EN: A SHALL be unchanged by CAPTURE, and ALU_CI SHALL be CI_IN sampled into a register on the accepted EXEC edge.

Verification
REQ-028 Reset then LOAD_A DIN=0x05, LOAD_B DIN=0x03, EXEC OPS_IN=0, CI=0 -> DONE after 4 cycles (SETTLE_CYCLES=2), ACC=0x08, OPCOUNT=1.
REQ-029 ALU_CHAIN_EN: A=0xFF, B=0x01, EXEC ADD -> ACC=0x00, FLAGS=0xD; a second EXEC ADD -> ALU_CI=1, ACC=0x02, FLAGS=0x0, A=0x02.
REQ-030 EXEC with OPS_IN=7 -> ERR high for 1 cycle, BUSY stays 0, ACC and OPCOUNT unchanged.
REQ-031 LOAD_A DIN=0x11 and EXEC while BUSY -> ignored: A unchanged, exactly one DONE produced.
REQ-032 RST asserted during the second SETTLE cycle -> next cycle IDLE, ACC=0, DONE never pulses; 256 completed EXECs -> OPCOUNT wraps to 0.
REQ-033 LOAD_A and EXEC in the same IDLE cycle with DIN=0x0A, B=0x0A, op ADD -> FLAGS EQO=1 and ACC=0x14.
